// File: rtl/aes_state_addr_seq.sv
// Row/column address sequencer for the AES state buffer: emits row*stride+col
// per beat over a valid/ready stream, one registered output stage.
module aes_state_addr_seq #(
    parameter int ROW_W    = 3,
    parameter int STRIDE_W = 5,
    parameter int PROD_W   = 7,
    parameter int ADDR_W   = 8
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                start,
    input  logic [ROW_W-1:0]    rows,
    input  logic [STRIDE_W-1:0] cols,
    input  logic [STRIDE_W-1:0] stride,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [ROW_W-1:0]    out_row,
    output logic [STRIDE_W-1:0] out_col,
    output logic                out_last,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0]    ROW_ONE = ROW_W'(1);
    localparam logic [STRIDE_W-1:0] COL_ONE = STRIDE_W'(1);

    // Models the 3x5 multiplier cell: product truncated to PROD_W bits.
    function automatic logic [PROD_W-1:0] mul_cell(input logic [ROW_W-1:0]    a,
                                                   input logic [STRIDE_W-1:0] b);
        logic [ROW_W+STRIDE_W-1:0] full;
        full = {{STRIDE_W{1'b0}}, a} * {{ROW_W{1'b0}}, b};
        return full[PROD_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_calc(input logic [ROW_W-1:0]    r,
                                                    input logic [STRIDE_W-1:0] c,
                                                    input logic [STRIDE_W-1:0] s);
        return {{(ADDR_W-PROD_W){1'b0}}, mul_cell(r, s)} + {{(ADDR_W-STRIDE_W){1'b0}}, c};
    endfunction

    state_t              state_q;
    logic [ROW_W-1:0]    rows_q;
    logic [STRIDE_W-1:0] cols_q;
    logic [STRIDE_W-1:0] stride_q;
    logic                busy_q;
    logic                done_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [ROW_W-1:0]    out_row_q;
    logic [STRIDE_W-1:0] out_col_q;

    logic                fire_s;
    logic                col_wrap_s;
    logic                empty_cfg_s;
    logic                first_last_s;
    logic [ROW_W-1:0]    row_d;
    logic [STRIDE_W-1:0] col_d;
    logic                last_d;
    logic [ADDR_W-1:0]   addr_d;

    // Next beat coordinates derived from the beat currently held in the stage.
    always_comb begin
        fire_s       = out_valid_q && out_ready;
        col_wrap_s   = (out_col_q == (cols_q - COL_ONE));
        row_d        = col_wrap_s ? (out_row_q + ROW_ONE) : out_row_q;
        col_d        = col_wrap_s ? {STRIDE_W{1'b0}} : (out_col_q + COL_ONE);
        last_d       = (row_d == (rows_q - ROW_ONE)) && (col_d == (cols_q - COL_ONE));
        addr_d       = addr_calc(row_d, col_d, stride_q);
        empty_cfg_s  = (rows == {ROW_W{1'b0}}) || (cols == {STRIDE_W{1'b0}});
        first_last_s = (rows == ROW_ONE) && (cols == COL_ONE);
    end

    // Sequencer FSM and registered output stage.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            rows_q      <= {ROW_W{1'b0}};
            cols_q      <= {STRIDE_W{1'b0}};
            stride_q    <= {STRIDE_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= {ADDR_W{1'b0}};
            out_row_q   <= {ROW_W{1'b0}};
            out_col_q   <= {STRIDE_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rows_q   <= rows;
                        cols_q   <= cols;
                        stride_q <= stride;
                        busy_q   <= 1'b1;
                        if (empty_cfg_s) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q     <= S_RUN;
                            out_valid_q <= 1'b1;
                            out_row_q   <= {ROW_W{1'b0}};
                            out_col_q   <= {STRIDE_W{1'b0}};
                            out_addr_q  <= {ADDR_W{1'b0}};
                            out_last_q  <= first_last_s;
                        end
                    end
                end
                S_RUN: begin
                    if (fire_s) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            out_row_q  <= row_d;
                            out_col_q  <= col_d;
                            out_addr_q <= addr_d;
                            out_last_q <= last_d;
                        end
                    end
                end
                S_DONE: begin
                    // An empty sweep arrives here with done low and spends one extra cycle.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_addr  = out_addr_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule
